sincos_cordic_rot: RTL and testbench

Iterative CORDIC engine in rotation mode. It takes an angle and produces sin and cos. It is the forward counterpart of the team's arcsin/arccos vectoring block: a value computed by arcsin/arccos can be fed back here to regenerate sin/cos, and the two share Q2.14 formats, func codes and the start/done style. One micro-rotation is performed per clock; the result is selected onto a 32-bit result bus by func.

---
 rtl/cordic_pkg.sv | 55 +++++
 rtl/cordic_rot_step.sv | 48 ++++
 rtl/sincos_cordic_rot.sv | 141 ++++++++++++++
 tb/tb_sincos_cordic_rot.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC sin/cos (rotation) and arcsin/arccos
// (vectoring) blocks: Q2.14 format constants, the CORDIC gain pre-scale,
// the arctangent table, result-select func codes and the FSM state type.
// -----------------------------------------------------------------------------
package cordic_pkg;

    // Q2.14 signed fixed point: 1.0 == 16384
    localparam int Q_WIDTH = 16;
    localparam int Q_FRAC  = 14;

    // Initial x so that the CORDIC gain (~1.64676) is cancelled at the end
    localparam logic signed [Q_WIDTH-1:0] K_INIT = 16'sh26DD;   // 0.60725
    localparam logic signed [Q_WIDTH-1:0] PI_2   = 16'sd25736;  // pi/2

    // Result-select codes; ARCCOS/ARCSIN belong to the vectoring block
    localparam logic [3:0] SIN    = 4'd0;
    localparam logic [3:0] COS    = 4'd1;
    localparam logic [3:0] ARCCOS = 4'd2;
    localparam logic [3:0] ARCSIN = 4'd3;

    localparam int ATAN_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // atan(2^-idx) in Q2.14; every entry is below 2^15
    function automatic logic [Q_WIDTH-1:0] atan_lut(input logic [3:0] idx);
        logic [Q_WIDTH-1:0] v;
        case (idx)
            4'd0:    v = 16'h3244;
            4'd1:    v = 16'h1DAC;
            4'd2:    v = 16'h0FAE;
            4'd3:    v = 16'h07F5;
            4'd4:    v = 16'h03FF;
            4'd5:    v = 16'h0200;
            4'd6:    v = 16'h0100;
            4'd7:    v = 16'h0080;
            4'd8:    v = 16'h0040;
            4'd9:    v = 16'h0020;
            4'd10:   v = 16'h0010;
            4'd11:   v = 16'h0008;
            4'd12:   v = 16'h0004;
            4'd13:   v = 16'h0002;
            4'd14:   v = 16'h0001;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// -----------------------------------------------------------------------------
// cordic_rot_step
// One combinational rotation-mode CORDIC micro-rotation. The sign of the
// residual angle z picks the rotation direction that drives z toward zero.
//
// Ports:
//   x, y, z   in   current vector and residual angle (signed Q2.14)
//   i         in   iteration index (shift amount)
//   atan      in   atan(2^-i) for this iteration
//   x_nxt,
//   y_nxt,
//   z_nxt     out  values after the micro-rotation
// -----------------------------------------------------------------------------
module cordic_rot_step
    import cordic_pkg::*;
(
    input  logic signed [Q_WIDTH-1:0] x,
    input  logic signed [Q_WIDTH-1:0] y,
    input  logic signed [Q_WIDTH-1:0] z,
    input  logic        [3:0]         i,
    input  logic        [Q_WIDTH-1:0] atan,
    output logic signed [Q_WIDTH-1:0] x_nxt,
    output logic signed [Q_WIDTH-1:0] y_nxt,
    output logic signed [Q_WIDTH-1:0] z_nxt
);

    logic signed [Q_WIDTH-1:0] w_x_sh;
    logic signed [Q_WIDTH-1:0] w_y_sh;
    logic signed [Q_WIDTH-1:0] w_atan;

    assign w_x_sh = x >>> i;
    assign w_y_sh = y >>> i;
    assign w_atan = $signed(atan);  // table entries < 2^15, so always positive

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        if (z >= 0) begin
            x_nxt = x - w_y_sh;
            y_nxt = y + w_x_sh;
            z_nxt = z - w_atan;
        end else begin
            x_nxt = x + w_y_sh;
            y_nxt = y - w_x_sh;
            z_nxt = z + w_atan;
        end
    end

endmodule

// File: rtl/sincos_cordic_rot.sv
// -----------------------------------------------------------------------------
// sincos_cordic_rot
// Iterative rotation-mode CORDIC: one micro-rotation per clock, producing
// sin and cos of a Q2.14 angle. Angles beyond +/-pi/2 are clamped.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   st        in   start request, sampled only while idle
//   theta_in  in   signed Q2.14 angle (radians), captured at start
//   func      in   result select: 0 = sin, 1 = cos, others read zero
//   busy      out  high while running or signalling done
//   done      out  one-cycle completion pulse
//   sin_out   out  registered signed Q2.14 sin
//   cos_out   out  registered signed Q2.14 cos
//   result    out  sign-extended sin/cos selected by func
// -----------------------------------------------------------------------------
module sincos_cordic_rot
    import cordic_pkg::*;
#(
    parameter int N = 16    // iteration count, 1..16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st,
    input  logic [Q_WIDTH-1:0]  theta_in,
    input  logic [3:0]          func,
    output logic                busy,
    output logic                done,
    output logic [Q_WIDTH-1:0]  sin_out,
    output logic [Q_WIDTH-1:0]  cos_out,
    output logic [31:0]         result
);

    localparam logic [3:0] LAST_I = 4'(N - 1);

    state_e                    r_state;
    logic [3:0]                r_i;
    logic signed [Q_WIDTH-1:0] r_x;
    logic signed [Q_WIDTH-1:0] r_y;
    logic signed [Q_WIDTH-1:0] r_z;
    logic signed [Q_WIDTH-1:0] r_sin;
    logic signed [Q_WIDTH-1:0] r_cos;
    logic                      r_busy;
    logic                      r_done;

    logic signed [Q_WIDTH-1:0] w_theta;
    logic signed [Q_WIDTH-1:0] w_theta_sat;
    logic signed [Q_WIDTH-1:0] w_x_nxt;
    logic signed [Q_WIDTH-1:0] w_y_nxt;
    logic signed [Q_WIDTH-1:0] w_z_nxt;

    assign w_theta = $signed(theta_in);

    // Clamp to [-pi/2, pi/2]: the arctan table sum only converges there
    always_comb begin
        w_theta_sat = w_theta;
        if (w_theta > PI_2)
            w_theta_sat = PI_2;
        else if (w_theta < -PI_2)
            w_theta_sat = -PI_2;
    end

    cordic_rot_step u_step (
        .x     (r_x),
        .y     (r_y),
        .z     (r_z),
        .i     (r_i),
        .atan  (atan_lut(r_i)),
        .x_nxt (w_x_nxt),
        .y_nxt (w_y_nxt),
        .z_nxt (w_z_nxt)
    );

    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values of x, y, z and i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (st) begin
                        r_x     <= K_INIT;
                        r_y     <= '0;
                        r_z     <= w_theta_sat;
                        r_i     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    r_i <= r_i + 4'd1;
                    if (r_i == LAST_I) begin
                        r_sin   <= w_y_nxt;
                        r_cos   <= w_x_nxt;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // st is deliberately not looked at here: no queueing
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sin_out = r_sin;
    assign cos_out = r_cos;

    always_comb begin
        case (func)
            SIN:     result = {{16{r_sin[Q_WIDTH-1]}}, r_sin};
            COS:     result = {{16{r_cos[Q_WIDTH-1]}}, r_cos};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_sincos_cordic_rot.sv
// -----------------------------------------------------------------------------
// tb_sincos_cordic_rot
// Self-checking bench for sincos_cordic_rot. Expected sin/cos values come
// from real-valued $sin/$cos of the clamped angle, with an 8 LSB tolerance.
// -----------------------------------------------------------------------------
module tb_sincos_cordic_rot;

    localparam int N   = 16;
    localparam int TOL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [15:0] theta_in;
    logic [3:0]  func;
    logic        busy;
    logic        done;
    logic [15:0] sin_out;
    logic [15:0] cos_out;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev_theta;

    always #5 clk = ~clk;

    sincos_cordic_rot #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .st       (st),
        .theta_in (theta_in),
        .func     (func),
        .busy     (busy),
        .done     (done),
        .sin_out  (sin_out),
        .cos_out  (cos_out),
        .result   (result)
    );

    // ---------------- reference model ----------------
    function automatic int sat_theta(input logic [15:0] th);
        int t;
        t = int'($signed(th));
        if (t > 25736)  return 25736;
        if (t < -25736) return -25736;
        return t;
    endfunction

    function automatic int ref_sin(input logic [15:0] th);
        real r;
        r = $sin(real'(sat_theta(th)) / 16384.0) * 16384.0;
        return int'(r);
    endfunction

    function automatic int ref_cos(input logic [15:0] th);
        real r;
        r = $cos(real'(sat_theta(th)) / 16384.0) * 16384.0;
        return int'(r);
    endfunction

    function automatic bit near(input int got, input int exp);
        return (got - exp <= TOL) && (exp - got <= TOL);
    endfunction

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int s32(input logic [31:0] v);
        return int'($signed(v));
    endfunction

    // Start one operation and wait (bounded) for done; lat = edges from the
    // st-sampling edge to the edge raising done, or -1 on timeout.
    task automatic run_op(input logic [15:0] th, output int lat);
        @(negedge clk);
        st       = 1'b1;
        theta_in = th;
        @(negedge clk);
        st       = 1'b0;
        theta_in = 16'($urandom);   // must not affect the running operation
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; st = 1'b0; func = 4'd0; theta_in = 16'h0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sin_out !== 16'h0) begin errors++; $display("FAIL reset_sin: got %h want 0000", sin_out); end
        checks++; if (cos_out !== 16'h0) begin errors++; $display("FAIL reset_cos: got %h want 0000", cos_out); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_fixed_angles();
        logic [15:0] angles [6];
        int lat;
        angles = '{16'h0000, 16'h2183, 16'hCDBC, 16'd30000, 16'(-30000), 16'h6488};
        foreach (angles[n]) begin
            run_op(angles[n], lat);
            prev_theta = angles[n];
            checks++; if (lat != N) begin errors++; $display("FAIL fixed_latency theta=%h: got %0d want %0d", angles[n], lat, N); end
            checks++; if (!near(s16(sin_out), ref_sin(angles[n]))) begin errors++;
                $display("FAIL fixed_sin theta=%h: got %0d want %0d+-%0d", angles[n], s16(sin_out), ref_sin(angles[n]), TOL); end
            checks++; if (!near(s16(cos_out), ref_cos(angles[n]))) begin errors++;
                $display("FAIL fixed_cos theta=%h: got %0d want %0d+-%0d", angles[n], s16(cos_out), ref_cos(angles[n]), TOL); end
            func = 4'd0; #1;
            checks++; if (!near(s32(result), ref_sin(angles[n]))) begin errors++;
                $display("FAIL fixed_result_sin theta=%h: got %h want %0d+-%0d", angles[n], result, ref_sin(angles[n]), TOL); end
            func = 4'd1; #1;
            checks++; if (!near(s32(result), ref_cos(angles[n]))) begin errors++;
                $display("FAIL fixed_result_cos theta=%h: got %h want %0d+-%0d", angles[n], result, ref_cos(angles[n]), TOL); end
            func = 4'd0;
        end
    endtask

    task automatic test_random();
        logic [15:0] th;
        int lat;
        for (int n = 0; n < 24; n++) begin
            th = 16'($urandom);
            run_op(th, lat);
            prev_theta = th;
            checks++; if (lat != N) begin errors++; $display("FAIL rand_latency theta=%h: got %0d want %0d", th, lat, N); end
            checks++; if (!near(s16(sin_out), ref_sin(th))) begin errors++;
                $display("FAIL rand_sin theta=%h: got %0d want %0d+-%0d", th, s16(sin_out), ref_sin(th), TOL); end
            checks++; if (!near(s16(cos_out), ref_cos(th))) begin errors++;
                $display("FAIL rand_cos theta=%h: got %0d want %0d+-%0d", th, s16(cos_out), ref_cos(th), TOL); end
        end
    endtask

    task automatic test_ignore_st();
        logic [15:0] th_a;
        int pulses;
        th_a = 16'h1800;
        pulses = 0;
        @(negedge clk);
        st = 1'b1; theta_in = th_a;
        @(negedge clk);
        st = 1'b0; theta_in = 16'hE000;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            st = (k == 3 || k == 4 || k == 9) ? 1'b1 : 1'b0;
            theta_in = 16'($urandom);
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    checks++; if (!near(s16(sin_out), ref_sin(th_a))) begin errors++;
                        $display("FAIL ignore_sin: got %0d want %0d+-%0d", s16(sin_out), ref_sin(th_a), TOL); end
                    checks++; if (!near(s16(cos_out), ref_cos(th_a))) begin errors++;
                        $display("FAIL ignore_cos: got %0d want %0d+-%0d", s16(cos_out), ref_cos(th_a), TOL); end
                end
                st = 1'b1;  // high during the DONE cycle: must be ignored
            end
        end
        st = 1'b0;
        prev_theta = th_a;
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int stamps [$];
        logic [15:0] th;
        th = 16'h1000;
        @(negedge clk);
        st = 1'b1; theta_in = th;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (done) begin
                stamps.push_back(cyc);
                checks++; if (!near(s16(sin_out), ref_sin(th))) begin errors++;
                    $display("FAIL b2b_sin: got %0d want %0d+-%0d", s16(sin_out), ref_sin(th), TOL); end
            end
        end
        st = 1'b0;
        checks++; if (stamps.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", stamps.size()); end
        for (int n = 1; n < stamps.size(); n++) begin
            checks++; if (stamps[n] - stamps[n-1] != N + 2) begin errors++;
                $display("FAIL b2b_period: got %0d want %0d", stamps[n] - stamps[n-1], N + 2); end
        end
        repeat (N + 4) @(negedge clk);
        prev_theta = th;
    endtask

    task automatic test_reset_midrun();
        logic [15:0] th;
        int lat;
        int pulses;
        th = 16'h0800;
        @(negedge clk);
        st = 1'b1; theta_in = th;
        @(negedge clk);
        st = 1'b0;
        repeat (7) @(negedge clk);      // seven micro-rotations done, i = 7
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b want 1", busy); end
        checks++; if (!near(s16(sin_out), ref_sin(prev_theta))) begin errors++;
            $display("FAIL hold_sin: got %0d want %0d+-%0d", s16(sin_out), ref_sin(prev_theta), TOL); end
        rst = 1'b1;
        #1;
        checks++; if (sin_out !== 16'h0) begin errors++; $display("FAIL abort_sin: got %h want 0000", sin_out); end
        checks++; if (cos_out !== 16'h0) begin errors++; $display("FAIL abort_cos: got %h want 0000", cos_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < N + 6; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
        run_op(th, lat);
        prev_theta = th;
        checks++; if (lat != N) begin errors++; $display("FAIL post_reset_latency: got %0d want %0d", lat, N); end
        checks++; if (!near(s16(sin_out), ref_sin(th))) begin errors++;
            $display("FAIL post_reset_sin: got %0d want %0d+-%0d", s16(sin_out), ref_sin(th), TOL); end
        checks++; if (!near(s16(cos_out), ref_cos(th))) begin errors++;
            $display("FAIL post_reset_cos: got %0d want %0d+-%0d", s16(cos_out), ref_cos(th), TOL); end
    endtask

    task automatic test_func();
        logic [3:0] codes [4];
        int lat;
        run_op(16'hCDBC, lat);
        checks++; if (lat != N) begin errors++; $display("FAIL func_latency: got %0d want %0d", lat, N); end
        func = 4'd0; #1;
        checks++; if (!near(s32(result), ref_sin(16'hCDBC))) begin errors++;
            $display("FAIL func_sin: got %h want %0d+-%0d", result, ref_sin(16'hCDBC), TOL); end
        func = 4'd1; #1;
        checks++; if (!near(s32(result), ref_cos(16'hCDBC))) begin errors++;
            $display("FAIL func_cos: got %h want %0d+-%0d", result, ref_cos(16'hCDBC), TOL); end
        codes = '{4'd2, 4'd3, 4'd7, 4'd15};
        foreach (codes[n]) begin
            func = codes[n]; #1;
            checks++; if (result !== 32'h0) begin errors++;
                $display("FAIL func_other code=%0d: got %h want 00000000", codes[n], result); end
        end
        func = 4'd0;
    endtask

    initial begin
        prev_theta = 16'h0;
        test_reset();
        test_fixed_angles();
        test_random();
        test_ignore_st();
        test_back_to_back();
        test_reset_midrun();
        test_func();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
